led_pattern_ctrl: RTL and testbench

//  Controller for the 16-LED bar on the EGo1 board. Debounces four push keys and sequences
//  the LED register through one of four patterns (rotate, bounce, fill, blink).

---
 rtl/led_pattern_ctrl_if.sv | 28 ++
 rtl/led_pattern_ctrl.sv | 177 +++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_ctrl_if.sv
// ============================================================================
//  Module   : led_pattern_ctrl_if
//  Brief    : Key inputs and LED/status outputs of the LED pattern controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface led_pattern_ctrl_if;
   logic        key_mode;
   logic        key_dir;
   logic        key_speed;
   logic        key_pause;
   logic [15:0] led;
   logic [1:0]  mode;
   logic        paused;

   modport master (
      output key_mode, key_dir, key_speed, key_pause,
      input  led, mode, paused
   );

   modport slave (
      input  key_mode, key_dir, key_speed, key_pause,
      output led, mode, paused
   );
endinterface

`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
// ============================================================================
//  Module   : led_pattern_ctrl
//  Brief    : Debounced four-key control of a 16-LED rotate/bounce/fill/blink bar.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module led_pattern_ctrl #(
   parameter logic [19:0] DB_CYCLES = 20'd999_999,
   parameter logic [23:0] STEP_BASE = 24'd4_999_999
) (
   input  wire logic         clk,
   input  wire logic         rst,
   led_pattern_ctrl_if.slave bus
);

   localparam int          c_NKEYS     = 4;
   localparam int          c_K_MODE    = 0;
   localparam int          c_K_DIR     = 1;
   localparam int          c_K_SPEED   = 2;
   localparam int          c_K_PAUSE   = 3;
   localparam logic [15:0] c_LED_ONE   = 16'h0001;
   localparam logic [15:0] c_LED_TWO   = 16'h0002;
   localparam logic [15:0] c_LED_TOP   = 16'h8000;
   localparam logic [15:0] c_LED_SUB   = 16'h4000;
   localparam logic [15:0] c_LED_EMPTY = 16'h0000;
   localparam logic [15:0] c_LED_FULL  = 16'hFFFF;
   localparam logic [15:0] c_LED_HALF  = 16'h00FF;

   typedef enum logic [1:0] {
      ROTATE = 2'd0,
      BOUNCE = 2'd1,
      FILL   = 2'd2,
      BLINK  = 2'd3
   } mode_t;

   logic [c_NKEYS-1:0] w_raw;
   logic [c_NKEYS-1:0] w_press;

   assign w_raw = {bus.key_pause, bus.key_speed, bus.key_dir, bus.key_mode};

   // Press pulse is registered alongside the debounced 0->1 flip.
   generate
      for (genvar k = 0; k < c_NKEYS; k++) begin : g_key
         logic        r_sync1;
         logic        r_sync2;
         logic        r_level;
         logic        r_press;
         logic [19:0] r_cnt;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_sync1 <= 1'b0;
               r_sync2 <= 1'b0;
               r_level <= 1'b0;
               r_press <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_sync1 <= w_raw[k];
               r_sync2 <= r_sync1;
               r_press <= 1'b0;
               if (r_sync2 != r_level) begin
                  if (r_cnt == DB_CYCLES) begin
                     r_level <= r_sync2;
                     r_press <= r_sync2;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 20'd1;
                  end
               end else begin
                  r_cnt <= '0;
               end
            end
         end

         assign w_press[k] = r_press;
      end
   endgenerate

   logic [23:0] r_base;
   logic [2:0]  r_sub;
   logic [1:0]  r_speed;
   logic        r_dir;
   logic        r_paused;
   mode_t       r_mode;
   logic [15:0] r_led;

   logic        w_base_tick;
   logic [2:0]  w_sub_tc;
   logic        w_step;
   logic        w_reflect;
   logic [15:0] w_led_step;
   logic [15:0] w_reload;
   mode_t       w_mode_next;

   always_comb begin
      case (r_speed)
         2'd0:    w_sub_tc = 3'd7;
         2'd1:    w_sub_tc = 3'd3;
         2'd2:    w_sub_tc = 3'd1;
         default: w_sub_tc = 3'd0;
      endcase
   end

   assign w_base_tick = ~r_paused & (r_base == STEP_BASE);
   assign w_step      = w_base_tick & (r_sub == w_sub_tc) & ~w_press[c_K_MODE];
   assign w_mode_next = mode_t'(r_mode + 2'd1);

   always_comb begin
      w_led_step = r_led;
      w_reflect  = 1'b0;
      case (r_mode)
         ROTATE: w_led_step = r_dir ? {r_led[14:0], r_led[15]} : {r_led[0], r_led[15:1]};
         BOUNCE: begin
            if (r_dir && (r_led == c_LED_TOP)) begin
               w_led_step = c_LED_SUB;
               w_reflect  = 1'b1;
            end else if (!r_dir && (r_led == c_LED_ONE)) begin
               w_led_step = c_LED_TWO;
               w_reflect  = 1'b1;
            end else begin
               w_led_step = r_dir ? {r_led[14:0], 1'b0} : {1'b0, r_led[15:1]};
            end
         end
         FILL: begin
            if (r_led == c_LED_FULL) w_led_step = c_LED_EMPTY;
            else w_led_step = r_dir ? {r_led[14:0], 1'b1} : {1'b1, r_led[15:1]};
         end
         default: w_led_step = ~r_led;
      endcase
   end

   always_comb begin
      case (w_mode_next)
         FILL:    w_reload = c_LED_EMPTY;
         BLINK:   w_reload = c_LED_HALF;
         default: w_reload = c_LED_ONE;
      endcase
   end

   // A mode press restarts timing and swallows any coincident step.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_base   <= '0;
         r_sub    <= '0;
         r_speed  <= 2'd2;
         r_dir    <= 1'b1;
         r_paused <= 1'b0;
         r_mode   <= ROTATE;
         r_led    <= c_LED_ONE;
      end else begin
         if (w_press[c_K_MODE]) begin
            r_mode <= w_mode_next;
            r_led  <= w_reload;
            r_base <= '0;
            r_sub  <= '0;
         end else begin
            if (w_step) r_led <= w_led_step;
            if (!r_paused) begin
               r_base <= w_base_tick ? 24'd0 : r_base + 24'd1;
               if (w_base_tick) r_sub <= (r_sub == w_sub_tc) ? 3'd0 : r_sub + 3'd1;
            end
            if (w_press[c_K_SPEED]) r_sub <= '0;
         end
         r_dir <= r_dir ^ (w_step & w_reflect) ^ w_press[c_K_DIR];
         if (w_press[c_K_SPEED]) r_speed <= r_speed + 2'd1;
         if (w_press[c_K_PAUSE]) r_paused <= ~r_paused;
      end
   end

   assign bus.led    = r_led;
   assign bus.mode   = r_mode;
   assign bus.paused = r_paused;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
// ============================================================================
//  Module   : tb_led_pattern_ctrl
//  Brief    : Directed and random key stimulus against a behavioural LED-bar model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_led_pattern_ctrl;

   localparam logic [19:0] c_DB       = 20'd3;
   localparam logic [23:0] c_SB       = 24'd1;
   localparam int          c_WIN      = int'(c_DB) + 1;
   localparam int          c_BASE_PER = int'(c_SB) + 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   led_pattern_ctrl_if bus ();

   led_pattern_ctrl #(
      .DB_CYCLES (c_DB),
      .STEP_BASE (c_SB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] m_led;
   int          m_mode;
   bit          m_dir;
   int          m_speed;
   bit          m_paused;
   int          m_cyc;
   int          m_ticks;
   logic [7:0]  m_hist [4];
   bit   [3:0]  m_level;
   bit   [3:0]  m_pend;

   function automatic logic [15:0] reload(input int mode);
      if (mode == 2) return 16'h0000;
      if (mode == 3) return 16'h00FF;
      return 16'h0001;
   endfunction

   function automatic logic [15:0] pattern_step(input logic [15:0] led, input int mode,
                                                input bit dir, output bit refl);
      int v;
      int p;
      int np;
      v    = int'(led);
      refl = 1'b0;
      case (mode)
         0: return dir ? 16'(((v << 1) | (v >> 15)) & 'hFFFF) : 16'(((v >> 1) | (v << 15)) & 'hFFFF);
         1: begin
            p = 0;
            for (int i = 0; i < 16; i++) if (led[i]) p = i;
            np = dir ? p + 1 : p - 1;
            if (np > 15) begin np = 14; refl = 1'b1; end
            if (np < 0)  begin np = 1;  refl = 1'b1; end
            return 16'(1 << np);
         end
         2: begin
            if (led == 16'hFFFF) return 16'h0000;
            return dir ? 16'((v << 1) | 1) : 16'((v >> 1) | 'h8000);
         end
         default: return ~led;
      endcase
   endfunction

   task automatic model_reset();
      m_led = 16'h0001; m_mode = 0; m_dir = 1'b1; m_speed = 2; m_paused = 1'b0;
      m_cyc = 0; m_ticks = 0; m_level = '0; m_pend = '0;
      for (int k = 0; k < 4; k++) m_hist[k] = '0;
   endtask

   task automatic model_edge();
      bit         pm, pd, ps, pp, base_tick, step, refl, all_diff;
      int         period;
      logic [3:0] raw;
      raw       = {bus.key_pause, bus.key_speed, bus.key_dir, bus.key_mode};
      pm = m_pend[0]; pd = m_pend[1]; ps = m_pend[2]; pp = m_pend[3];
      period    = 8 >> m_speed;
      base_tick = !m_paused && (m_cyc % c_BASE_PER == c_BASE_PER - 1);
      step      = base_tick && (m_ticks % period == period - 1) && !pm;
      refl      = 1'b0;
      if (pm) begin
         m_mode  = (m_mode + 1) % 4;
         m_led   = reload(m_mode);
         m_cyc   = 0;
         m_ticks = 0;
      end else begin
         if (step) m_led = pattern_step(m_led, m_mode, m_dir, refl);
         if (!m_paused) begin
            m_cyc++;
            if (base_tick) m_ticks++;
         end
         if (ps) m_ticks = 0;
      end
      m_dir = m_dir ^ refl ^ pd;
      if (ps) m_speed = (m_speed + 1) % 4;
      if (pp) m_paused = !m_paused;
      // A level flips once the last c_WIN synchronised samples all disagree with it.
      for (int k = 0; k < 4; k++) begin
         all_diff = 1'b1;
         for (int j = 1; j <= c_WIN; j++) if (m_hist[k][j] == m_level[k]) all_diff = 1'b0;
         m_pend[k] = 1'b0;
         if (all_diff) begin
            m_level[k] = ~m_level[k];
            m_pend[k]  = m_level[k];
         end
         m_hist[k] = {m_hist[k][6:0], raw[k]};
      end
   endtask

   always @(posedge clk) begin
      if (rst) model_reset();
      else model_edge();
   end

   task automatic check(input string tag);
      n_tests++;
      assert (bus.led === m_led) else begin
         n_fail++; $error("FAIL %s led got %h want %h", tag, bus.led, m_led);
      end
      n_tests++;
      assert (bus.mode === 2'(m_mode)) else begin
         n_fail++; $error("FAIL %s mode got %0d want %0d", tag, bus.mode, m_mode);
      end
      n_tests++;
      assert (bus.paused === m_paused) else begin
         n_fail++; $error("FAIL %s paused got %0d want %0d", tag, bus.paused, m_paused);
      end
   endtask

   task automatic check_const(input string tag, input logic [15:0] led, input logic [1:0] mode);
      n_tests++;
      assert (bus.led === led) else begin
         n_fail++; $error("FAIL %s led got %h want %h", tag, bus.led, led);
      end
      n_tests++;
      assert (bus.mode === mode) else begin
         n_fail++; $error("FAIL %s mode got %0d want %0d", tag, bus.mode, mode);
      end
   endtask

   task automatic check_paused(input string tag, input logic p);
      n_tests++;
      assert (bus.paused === p) else begin
         n_fail++; $error("FAIL %s paused got %0d want %0d", tag, bus.paused, p);
      end
   endtask

   task automatic run(input int n, input string tag);
      repeat (n) begin
         @(negedge clk);
         check(tag);
      end
   endtask

   task automatic set_key(input int k, input logic v);
      case (k)
         0:       bus.key_mode  = v;
         1:       bus.key_dir   = v;
         2:       bus.key_speed = v;
         default: bus.key_pause = v;
      endcase
   endtask

   task automatic tap(input int k, input string tag);
      set_key(k, 1'b1);
      run(8, tag);
      set_key(k, 1'b0);
      run(8, tag);
   endtask

   function automatic int edges_to_strobe();
      int c, t, period;
      bit bt;
      c = m_cyc; t = m_ticks; period = 8 >> m_speed;
      for (int d = 1; d < 100; d++) begin
         bt = !m_paused && (c % c_BASE_PER == c_BASE_PER - 1);
         if (bt && (t % period == period - 1) && d >= 7) return d;
         c++;
         if (bt) t++;
      end
      return -1;
   endfunction

   initial begin
      bit found;
      rst = 1'b1;
      bus.key_mode = 1'b0; bus.key_dir = 1'b0; bus.key_speed = 1'b0; bus.key_pause = 1'b0;
      repeat (3) @(negedge clk);
      check_const("reset", 16'h0001, 2'd0);
      check_paused("reset_paused", 1'b0);
      rst = 1'b0;

      // Rotate left at speed 2: one step every four cycles.
      run(4, "rot1");  check_const("rot_0002", 16'h0002, 2'd0);
      run(4, "rot2");  check_const("rot_0004", 16'h0004, 2'd0);
      run(56, "rot3"); check_const("rot_wrap", 16'h0001, 2'd0);

      // Short bounce on key_dir is rejected; a long hold toggles direction.
      set_key(1, 1'b1); run(2, "dir_bounce");
      set_key(1, 1'b0); run(12, "dir_bounce");
      tap(1, "dir_hold");
      run(12, "rot_right");
      tap(1, "dir_back");

      // BOUNCE from 0001 leftwards, reflecting at the top end.
      set_key(0, 1'b1); run(8, "mode_bounce");
      check_const("bounce_entry", 16'h0001, 2'd1);
      set_key(0, 1'b0); run(63, "bounce_run");
      check_const("bounce_reflect", 16'h4000, 2'd1);
      run(4, "bounce_next");
      check_const("bounce_2000", 16'h2000, 2'd1);

      // FILL (direction now right after the reflection), then BLINK.
      set_key(0, 1'b1); run(8, "mode_fill");
      check_const("fill_entry", 16'h0000, 2'd2);
      set_key(0, 1'b0); run(63, "fill_run");
      check_const("fill_full", 16'hFFFF, 2'd2);
      run(4, "fill_clear");
      check_const("fill_empty", 16'h0000, 2'd2);
      set_key(0, 1'b1); run(8, "mode_blink");
      check_const("blink_entry", 16'h00FF, 2'd3);
      set_key(0, 1'b0); run(3, "blink1");
      check_const("blink_ff00", 16'hFF00, 2'd3);
      run(4, "blink2");
      check_const("blink_00ff", 16'h00FF, 2'd3);

      // Pause freezes stepping; speed 2 -> 3 -> 0.
      tap(3, "pause_on");
      run(60, "paused_run");
      check_paused("paused_set", 1'b1);
      tap(3, "pause_off");
      run(12, "resumed");
      check_paused("paused_clr", 1'b0);
      tap(2, "speed3");
      tap(2, "speed0");
      run(48, "slow_run");

      // Mode and dir presses landing on a step strobe.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (edges_to_strobe() == 7) found = 1'b1;
         else run(1, "align");
      end
      n_tests++;
      assert (found) else begin
         n_fail++; $error("FAIL align got %0d want %0d", found, 1);
      end
      check_const("pre_collide", m_led, 2'd3);
      set_key(0, 1'b1); set_key(1, 1'b1);
      run(8, "collide");
      check_const("collide_reload", 16'h0001, 2'd0);
      set_key(0, 1'b0); set_key(1, 1'b0);
      run(40, "after_collide");

      // Reset in the middle of a paused FILL run.
      tap(0, "to_bounce");
      tap(0, "to_fill");
      run(20, "fill_pre_rst");
      tap(3, "fill_pause");
      rst = 1'b1;
      @(negedge clk);
      check_const("mid_reset", 16'h0001, 2'd0);
      check_paused("mid_reset_paused", 1'b0);
      rst = 1'b0;
      run(10, "post_reset");

      // Random key activity with occasional reset.
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 4; k++)
            if ($urandom_range(0, 9) == 0) begin
               case (k)
                  0:       bus.key_mode  = ~bus.key_mode;
                  1:       bus.key_dir   = ~bus.key_dir;
                  2:       bus.key_speed = ~bus.key_speed;
                  default: bus.key_pause = ~bus.key_pause;
               endcase
            end
         rst = ($urandom_range(0, 499) == 0);
         run(1, "random");
      end
      rst = 1'b0;
      bus.key_mode = 1'b0; bus.key_dir = 1'b0; bus.key_speed = 1'b0; bus.key_pause = 1'b0;
      run(20, "drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
